// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, operand select and shift/ALU control decode.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    input  logic            exm_wr_en_i,
    input  logic [4:0]      exm_rd_i,
    input  logic [XLEN-1:0] exm_data_i,
    input  logic            wb_wr_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] a_o,
    output logic [XLEN-1:0] b_o,
    output logic [2:0]      op_o,
    output logic            arithmetic_o,
    output logic            shift_sel_o,
    output logic [4:0]      rd_o,
    output logic            wr_en_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] pc_o
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic            is_op, is_imm, is_shift, arith_n, load;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, imm, b_n;
    logic            wen_q;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign rs1      = instr_i[19:15];
    assign rs2      = instr_i[24:20];
    assign rd       = instr_i[11:7];
    assign is_op    = opcode == 7'b0110011;
    assign is_imm   = opcode == 7'b0010011;
    assign is_shift = funct3 == 3'b001 || funct3 == 3'b101;

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register
    assign rs1_fwd = rs1 == 5'd0 ? '0 :
                     (exm_wr_en_i && exm_rd_i == rs1) ? exm_data_i :
                     (wb_wr_en_i && wb_rd_i == rs1) ? wb_data_i : rs1_data_i;
    assign rs2_fwd = rs2 == 5'd0 ? '0 :
                     (exm_wr_en_i && exm_rd_i == rs2) ? exm_data_i :
                     (wb_wr_en_i && wb_rd_i == rs2) ? wb_data_i : rs2_data_i;

    // Immediate shifts carry a 5-bit shamt; instr[30] there is the SRAI flag, not immediate data
    assign imm = is_shift ? {{(XLEN-5){1'b0}}, instr_i[24:20]} : {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign b_n = is_op ? rs2_fwd : imm;
    assign arith_n = is_op  ? instr_i[30] && (funct3 == 3'b000 || funct3 == 3'b101) :
                     is_imm ? instr_i[30] && funct3 == 3'b101 : 1'b0;

    assign ready_o = ~valid_o | ready_i;
    assign load    = valid_i & ready_o & ~flush_i;
    assign wr_en_o = valid_o & wen_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o      <= 1'b0;
            a_o          <= '0;
            b_o          <= '0;
            op_o         <= '0;
            arithmetic_o <= 1'b0;
            shift_sel_o  <= 1'b0;
            rd_o         <= '0;
            wen_q        <= 1'b0;
            illegal_o    <= 1'b0;
            pc_o         <= '0;
        end else begin
            valid_o <= flush_i ? 1'b0 : load ? 1'b1 : ready_i ? 1'b0 : valid_o;
            if (load) begin
                a_o          <= rs1_fwd;
                b_o          <= b_n;
                op_o         <= funct3;
                arithmetic_o <= arith_n;
                shift_sel_o  <= is_shift;
                rd_o         <= rd;
                wen_q        <= (is_op || is_imm) && rd != 5'd0;
                illegal_o    <= ~(is_op || is_imm);
                pc_o         <= pc_i;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors with a scoreboard queue, plus stall/flush/reset sequences.
module tb_id_ex_stage;
    logic        clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1;
    logic [31:0] instr_i = '0, pc_i = '0, rs1_data_i = '0, rs2_data_i = '0, exm_data_i = '0, wb_data_i = '0;
    logic        exm_wr_en_i = 1'b0, wb_wr_en_i = 1'b0;
    logic [4:0]  exm_rd_i = '0, wb_rd_i = '0;
    logic        ready_o, valid_o, arithmetic_o, shift_sel_o, wr_en_o, illegal_o;
    logic [31:0] a_o, b_o, pc_o;
    logic [2:0]  op_o;
    logic [4:0]  rd_o;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .exm_wr_en_i(exm_wr_en_i), .exm_rd_i(exm_rd_i), .exm_data_i(exm_data_i),
        .wb_wr_en_i(wb_wr_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .a_o(a_o), .b_o(b_o), .op_o(op_o),
        .arithmetic_o(arithmetic_o), .shift_sel_o(shift_sel_o), .rd_o(rd_o), .wr_en_o(wr_en_o),
        .illegal_o(illegal_o), .pc_o(pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr, pc, rs1, rs2;
        logic        exm_we;
        logic [4:0]  exm_rd;
        logic [31:0] exm_d;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        ar, sh;
        logic [4:0]  rd;
        logic        we, ill, chk;
    } vec_t;

    vec_t v[13];
    vec_t q[$];
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        instr_i = x.instr; pc_i = x.pc; rs1_data_i = x.rs1; rs2_data_i = x.rs2;
        exm_wr_en_i = x.exm_we; exm_rd_i = x.exm_rd; exm_data_i = x.exm_d;
        wb_wr_en_i = x.wb_we; wb_rd_i = x.wb_rd; wb_data_i = x.wb_d;
    endtask

    // One-cycle valid pulse; the model accepts when the stage is empty or draining
    task automatic load(input vec_t x);
        drive(x);
        valid_i = 1'b1;
        if ((!valid_o || ready_i) && !flush_i) q.push_back(x);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic chk_held(input vec_t x, input string nm);
        chk({nm, "_valid"}, {63'd0, valid_o}, 64'd1);
        chk({nm, "_ready"}, {63'd0, ready_o}, 64'd0);
        chk({nm, "_ab"}, {a_o, b_o}, {x.a, x.b});
        chk({nm, "_ctl"}, {40'd0, op_o, arithmetic_o, shift_sel_o, rd_o, wr_en_o, illegal_o, pc_o},
            {40'd0, x.op, x.ar, x.sh, x.rd, x.we, x.ill, x.pc});
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output pc=%h", pc_o);
            end else begin
                vec_t e;
                e = q.pop_front();
                if (wr_en_o !== e.we || illegal_o !== e.ill || rd_o !== e.rd || shift_sel_o !== e.sh ||
                    pc_o !== e.pc || (e.chk && (a_o !== e.a || b_o !== e.b || op_o !== e.op || arithmetic_o !== e.ar))) begin
                    n_err++;
                    $display("FAIL vec pc=%h got a=%h b=%h op=%0d ar=%b sh=%b rd=%0d we=%b ill=%b pc=%h exp a=%h b=%h op=%0d ar=%b sh=%b rd=%0d we=%b ill=%b",
                             e.pc, a_o, b_o, op_o, arithmetic_o, shift_sel_o, rd_o, wr_en_o, illegal_o, pc_o,
                             e.a, e.b, e.op, e.ar, e.sh, e.rd, e.we, e.ill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        v[0]  = '{32'h40335293, 32'h100, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h80000000, 32'h3, 3'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1};
        v[1]  = '{32'h403100B3, 32'h104, 32'hAAAA, 32'hBBBB, 1'b1, 5'd2, 32'h10, 1'b1, 5'd3, 32'h7,
                  32'h10, 32'h7, 3'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
        v[2]  = '{32'h403100B3, 32'h108, 32'hAAAA, 32'hBBBB, 1'b1, 5'd2, 32'h10, 1'b1, 5'd2, 32'h20,
                  32'h10, 32'hBBBB, 3'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
        v[3]  = '{32'hFFF00013, 32'h10C, 32'h999, 32'h0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66,
                  32'h0, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
        v[4]  = '{32'h009403B3, 32'h110, 32'h1111, 32'h2222, 1'b0, 5'd8, 32'hBAD, 1'b0, 5'd9, 32'hBAD,
                  32'h1111, 32'h2222, 3'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1};
        v[5]  = '{32'h40C5D533, 32'h114, 32'hF0000000, 32'h4, 1'b1, 5'd5, 32'h77, 1'b1, 5'd11, 32'hABCD,
                  32'hABCD, 32'h4, 3'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1};
        v[6]  = '{32'h01F21193, 32'h118, 32'h1, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h1, 32'h1F, 3'd1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1};
        v[7]  = '{32'h8000A113, 32'h11C, 32'h333, 32'h0, 1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd1, 32'hBEEF,
                  32'hDEAD, 32'hFFFFF800, 3'd2, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1};
        v[8]  = '{32'h4002C313, 32'h120, 32'h5A5A, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h5A5A, 32'h400, 3'd4, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1};
        v[9]  = '{32'h40006FB3, 32'h124, 32'h123, 32'h456, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'h0,
                  32'h0, 32'h0, 3'd6, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1};
        v[10] = '{32'h0000A083, 32'h128, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h0, 32'h0, 3'd2, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        v[11] = '{32'h0000006F, 32'h12C, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        v[12] = '{32'h0074D413, 32'h130, 32'h1, 32'h0, 1'b0, 5'd9, 32'h99, 1'b1, 5'd9, 32'h44,
                  32'h44, 32'h7, 3'd5, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_ready", {63'd0, ready_o}, 64'd1);
        chk("reset_regs", {valid_o, wr_en_o, illegal_o, arithmetic_o, shift_sel_o, op_o, rd_o, a_o, b_o, pc_o},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0});
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 13; i++) load(v[i]);
        @(posedge clk_i); #1;
        chk("drain_valid", {62'd0, valid_o, wr_en_o}, 64'd0);

        // Stall: hold SRAI while every input changes underneath it
        ready_i = 1'b0;
        load(v[0]);
        for (int k = 0; k < 3; k++) begin
            drive(v[k + 4]);
            valid_i = 1'b1;
            @(posedge clk_i); #1;
            chk_held(v[0], "stall");
        end
        ready_i = 1'b1;
        load(v[4]);
        @(posedge clk_i); #1;

        // Flush wins over a simultaneous load
        flush_i = 1'b1;
        load(v[5]);
        flush_i = 1'b0;
        chk("flush_load", {62'd0, valid_o, wr_en_o}, 64'd0);

        // Flush kills a held instruction
        ready_i = 1'b0;
        load(v[6]);
        chk_held(v[6], "pre_flush");
        flush_i = 1'b1;
        void'(q.pop_back());
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_held", {62'd0, valid_o, wr_en_o}, 64'd0);
        chk("flush_ready", {63'd0, ready_o}, 64'd1);

        // Asynchronous reset mid-cycle while stalled
        load(v[1]);
        #2;
        rst_i = 1'b1;
        #1;
        q.delete();
        chk("async_rst", {valid_o, wr_en_o, ready_o, a_o, pc_o}, {1'b0, 1'b0, 1'b1, 32'd0, 32'd0});
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ready_i = 1'b1;
        load(v[10]);
        load(v[7]);
        @(posedge clk_i); #1;
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
